// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains a read-latency-1 FIFO into a packetised valid/ready byte stream
module fifo_drain #(
    parameter int PKT_LEN = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy
);
    localparam int                WCNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(PKT_LEN - 1);

    // Two-entry in-order buffer: head_q feeds the stream, tail_q holds the second word.
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [7:0]        head_q, head_d;
    logic [7:0]        tail_q, tail_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic              pop;
    logic              capture;
    logic [2:0]        slots_needed;

    // Stream outputs come straight from the head entry; reset keeps them quiet.
    always_comb begin
        m_valid = ~reset & (occ_q != 2'd0);
        m_data  = reset ? 8'h00 : head_q;
        m_last  = m_valid & (wcnt_q == WCNT_MAX);
        busy    = ~reset & (inflight_q | (occ_q != 2'd0));
    end

    // Issue a read only if the word it returns is guaranteed a free slot on arrival.
    always_comb begin
        pop          = m_valid & m_ready;
        capture      = inflight_q;
        slots_needed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd      = enable & ~fifo_empty & ~reset & (slots_needed < 3'd2);
    end

    // Buffer shift/append, read-pipeline tracking and packet word counting.
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rd;
        wcnt_d     = wcnt_q;
        case ({pop, capture})
            2'b10: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_data;
                end else begin
                    tail_d = fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Head leaves and the new word joins behind whatever remains.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end else begin
                    head_d = fifo_data;
                end
            end
            default: begin
            end
        endcase
        if (pop) begin
            wcnt_d = (wcnt_q == WCNT_MAX) ? '0 : wcnt_q + WCNT_W'(1);
        end
    end

    // State register; reset drops any buffered or in-flight words.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 8'h00;
            tail_q     <= 8'h00;
            wcnt_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            wcnt_q     <= wcnt_d;
        end
    end

    // A returning word must never land in a full buffer that is not also draining.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(capture && !pop && (occ_q == 2'd2)));
        end
    end
endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - directed self-checking bench for fifo_drain
module tb_fifo_drain;
    localparam int PKT_LEN = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;

    always #5 clock = ~clock;

    fifo_drain #(.PKT_LEN(PKT_LEN)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fq[$];
    logic [7:0] eq[$];
    int         cyc = 0;
    int         pkt_cnt = 0;
    int         rd_cnt, pop_cnt, last_cnt;
    int         first_rd, first_vld, first_pop, last_pop;
    int         mark, n0;
    logic       hold_q = 1'b0;
    logic [7:0] hold_data;
    logic       hold_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        rd_cnt    = 0;
        pop_cnt   = 0;
        last_cnt  = 0;
        first_rd  = -1;
        first_vld = -1;
        first_pop = -1;
        last_pop  = -1;
    endtask

    // One clock cycle: entered and left at a falling edge, FIFO model updated after the rising edge.
    task automatic cycle();
        logic       rd_s;
        logic       pop_s;
        logic [7:0] exp_w;
        fifo_empty = (fq.size() == 0);
        #1;
        rd_s  = fifo_rd;
        pop_s = m_valid & m_ready;
        if (hold_q && !reset) begin
            check("hold_valid", m_valid, 1'b1);
            check("hold_data", m_data, hold_data);
            check("hold_last", m_last, hold_last);
        end
        if (fifo_empty) check("rd_when_empty", fifo_rd, 1'b0);
        if (rd_s) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (pop_s) begin
            if (eq.size() == 0) begin
                check("pop_unexpected", pop_s, 1'b0);
            end else begin
                exp_w = eq.pop_front();
                check("m_data", m_data, exp_w);
                check("m_last", m_last, pkt_cnt == PKT_LEN - 1);
                pkt_cnt = (pkt_cnt + 1) % PKT_LEN;
            end
            pop_cnt++;
            if (m_last) last_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        hold_q    = m_valid & ~m_ready & ~reset;
        hold_data = m_data;
        hold_last = m_last;
        @(posedge clock);
        #1;
        if (rd_s && fq.size() > 0) fifo_data = fq.pop_front();
        else                       fifo_data = 8'($urandom);
        fifo_empty = (fq.size() == 0);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        fq.delete();
        eq.delete();
        pkt_cnt = 0;
        hold_q  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        m_ready    = 1'b0;
        fifo_data  = 8'h00;
        fifo_empty = 1'b1;
        reset_stats();
        @(negedge clock);

        // Reset state, during and after the reset edge.
        cycle();
        enable = 1'b1;
        #1;
        check("rst_fifo_rd", fifo_rd, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        cycle();
        reset  = 1'b0;
        enable = 1'b0;
        check("post_rst_m_valid", m_valid, 1'b0);
        check("post_rst_m_data", m_data, 8'h00);
        check("post_rst_busy", busy, 1'b0);

        // Streaming 0x01..0x20 at full rate.
        for (int i = 1; i <= 32; i++) begin
            fq.push_back(8'(i));
            eq.push_back(8'(i));
        end
        reset_stats();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int n = 0; n < 60 && eq.size() > 0; n++) cycle();
        check("stream_drained", eq.size(), 0);
        check("stream_latency", first_vld - first_rd, 2);
        check("stream_span", last_pop - first_pop, 31);
        check("stream_lasts", last_cnt, 2);
        check("stream_idle_busy", busy, 1'b0);

        // Backpressure right from the first word.
        for (int i = 1; i <= 8; i++) begin
            fq.push_back(8'(i));
            eq.push_back(8'(i));
        end
        reset_stats();
        m_ready = 1'b0;
        for (int n = 0; n < 10 && !m_valid; n++) cycle();
        check("bp_valid", m_valid, 1'b1);
        for (int n = 0; n < 5; n++) begin
            check("bp_data", m_data, 8'h01);
            cycle();
        end
        check("bp_rd_pulses", rd_cnt, 2);
        m_ready = 1'b1;
        for (int n = 0; n < 30 && eq.size() > 0; n++) cycle();
        check("bp_drained", eq.size(), 0);
        check("bp_idle_busy", busy, 1'b0);

        // FIFO runs dry after three words.
        for (int i = 1; i <= 3; i++) begin
            fq.push_back(8'(8'hA0 + i));
            eq.push_back(8'(8'hA0 + i));
        end
        reset_stats();
        for (int n = 0; n < 20 && eq.size() > 0; n++) cycle();
        check("empty_drained", eq.size(), 0);
        check("empty_busy_after_pop3", busy, 1'b0);
        cycle();
        check("empty_rd_pulses", rd_cnt, 3);

        // Enable dropped mid-stream.
        for (int i = 1; i <= 32; i++) begin
            fq.push_back(8'(8'h40 + i));
            eq.push_back(8'(8'h40 + i));
        end
        reset_stats();
        for (int n = 0; n < 8; n++) cycle();
        enable = 1'b0;
        #1;
        check("drop_rd_same_cycle", fifo_rd, 1'b0);
        mark = pop_cnt;
        for (int n = 0; n < 6; n++) cycle();
        check("drop_words_le2", (pop_cnt - mark) <= 2, 1'b1);
        check("drop_m_valid", m_valid, 1'b0);
        check("drop_busy", busy, 1'b0);
        enable = 1'b1;
        for (int n = 0; n < 60 && eq.size() > 0; n++) cycle();
        check("drop_resume_drained", eq.size(), 0);

        // Reset with two words buffered, five words into a packet.
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            fq.push_back(8'(i));
            eq.push_back(8'(i));
        end
        reset_stats();
        for (int n = 0; n < 20 && pop_cnt < 5; n++) cycle();
        check("mid_pops", pop_cnt, 5);
        m_ready = 1'b0;
        cycle();
        check("mid_buffered_valid", m_valid, 1'b1);
        reset   = 1'b1;
        m_ready = 1'b1;
        #1;
        check("mid_rst_fifo_rd", fifo_rd, 1'b0);
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        cycle();
        reset = 1'b0;
        check("mid_after_m_valid", m_valid, 1'b0);
        check("mid_after_busy", busy, 1'b0);
        eq = fq;
        n0 = eq.size();
        pkt_cnt = 0;
        hold_q  = 1'b0;
        reset_stats();
        for (int n = 0; n < 120 && eq.size() > 0; n++) cycle();
        check("mid_resume_drained", eq.size(), 0);
        check("mid_resume_lasts", last_cnt, n0 / PKT_LEN);

        // Random backpressure over 1000 words.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            fq.push_back(8'(i * 37 + 5));
            eq.push_back(8'(i * 37 + 5));
        end
        reset_stats();
        for (int n = 0; n < 5000 && eq.size() > 0; n++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check("rand_drained", eq.size(), 0);
        check("rand_pops", pop_cnt, 1000);
        check("rand_lasts", last_cnt, 62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter PKT_LEN, default 16, range 2..256, words per output packet.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-004 SHALL have port enable  input  1  permits new FIFO reads when 1.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_rd  output  1  FIFO read strobe, one word per cycle asserted.
REQ-007 SHALL have port fifo_data  input  8  FIFO registered read data, valid the cycle after fifo_rd.
REQ-008 SHALL have port m_data  output  8  output stream data.
REQ-009 SHALL have port m_valid  output  1  output word available.
REQ-010 SHALL have port m_ready  input  1  downstream accepts word.
REQ-011 SHALL have port m_last  output  1  marks final word of a PKT_LEN-word packet.
REQ-012 SHALL have port busy  output  1  read in flight or buffer non-empty.

Function
REQ-013 SHALL hold a 2-entry in-order skid buffer; occ = stored entries (0..2); m_data/m_valid driven from the head entry.
REQ-014 SHALL define pop = m_valid & m_ready; handshake completes on the clock edge where pop=1.
REQ-015 SHALL set inflight = 1 for exactly the cycle after a cycle with fifo_rd=1, else 0.
REQ-016 SHALL drive fifo_rd combinationally = enable & ~fifo_empty & ~reset & ((occ + inflight - pop) < 2).
REQ-017 SHALL capture fifo_data into the buffer tail on the rising edge ending each cycle where inflight=1; no other capture.
REQ-018 SHALL, on the same edge with capture and pop, remove head and append new word; occ unchanged.
REQ-019 SHALL never overflow: REQ-016 guarantees a free slot for every capture; a capture into a full buffer is a design error flagged by assertion.
REQ-020 SHALL sustain 1 word/cycle when enable=1, fifo_empty=0, m_ready=1 continuously; first m_valid 2 cycles after first fifo_rd cycle (read latency 1 + capture register).
REQ-021 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-022 SHALL keep m_valid=1 once asserted until pop.
REQ-023 SHALL maintain word counter wcnt, width ceil(log2(PKT_LEN)), increment on pop, wrap from PKT_LEN-1 to 0.
REQ-024 SHALL assert m_last = m_valid & (wcnt == PKT_LEN-1).
REQ-025 SHALL on enable 1->0 stop new fifo_rd the same cycle; in-flight and buffered words still delivered; wcnt not cleared.
REQ-026 SHALL ignore fifo_data in cycles with inflight=0.
REQ-027 SHALL drive busy = inflight | (occ != 0).
REQ-028 SHALL not depend on fifo_empty except through REQ-016; fifo_empty falling with enable=1 yields fifo_rd in that same cycle.

Reset
REQ-029 SHALL on reset clear occ, inflight, wcnt to 0 and buffer contents to 0.
REQ-030 SHALL hold outputs during and after reset edge: fifo_rd=0, m_valid=0, m_last=0, m_data=8'h00, busy=0.
REQ-031 SHALL on reset mid-operation discard in-flight and buffered words; the FIFO word read in flight is lost, and the next packet begins with wcnt=0.

Verification
REQ-032 SHALL verify streaming: FIFO preloaded 0x01..0x20, enable=1, m_ready=1 -> 32 words 0x01..0x20 on consecutive cycles, m_last on 0x10 and 0x20.
REQ-033 SHALL verify backpressure: m_ready=0 for 5 cycles after first m_valid -> exactly 2 fifo_rd pulses total, m_data=0x01 stable, no loss or reorder after m_ready=1.
REQ-034 SHALL verify empty boundary: FIFO holds 3 words -> 3 fifo_rd, fifo_rd=0 after fifo_empty=1, busy falls after third pop.
REQ-035 SHALL verify enable drop: enable 1->0 during streaming -> fifo_rd=0 same cycle, at most 2 further words delivered, then m_valid=0.
REQ-036 SHALL verify reset mid-packet: reset after 5 pops with 2 words buffered -> next cycle m_valid=0, busy=0; resumed stream gives m_last on 16th subsequent word.
REQ-037 SHALL verify random m_ready (50%) over 1000 words -> output equals FIFO input order, m_last every 16th word, REQ-019 assertion never fires.
